// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the elevator car scheduler.
//   elev_state_t : scheduler FSM states (IDLE, MOVE, DOOR)
//   DEF_FLOORS   : default number of floors
//   floor_idx_t  : binary floor index for the default floor count
//   timer_width  : width of the shared move/door timer
// ---------------------------------------------------------------------------
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } elev_state_t;

    localparam int DEF_FLOORS = 4;

    typedef logic [$clog2(DEF_FLOORS)-1:0] floor_idx_t;

    // One extra bit over the larger of the two intervals keeps the limit
    // value representable even when an interval is an exact power of two.
    function automatic int timer_width(input int move_cycles, input int door_cycles);
        return $clog2((move_cycles > door_cycles) ? move_cycles : door_cycles) + 1;
    endfunction

endpackage

// File: rtl/elevator_if.sv
// ---------------------------------------------------------------------------
// elevator_if
// Request/status bundle between the per-floor button latches and the car
// scheduler.
//   req       : pending request per floor (button -> scheduler)
//   floor     : current car floor, binary
//   dir_up    : current or last travel direction is up
//   moving    : car is travelling between floors
//   door_open : door is held open at the current floor
//   arrive    : one-hot, one-cycle pulse that clears the served button
// Modports: master = scheduler side, slave = button side.
// ---------------------------------------------------------------------------
interface elevator_if
    import elevator_pkg::*;
#(
    parameter int FLOORS = DEF_FLOORS
) ();

    logic [FLOORS-1:0]         req;
    logic [$clog2(FLOORS)-1:0] floor;
    logic                      dir_up;
    logic                      moving;
    logic                      door_open;
    logic [FLOORS-1:0]         arrive;

    modport master (
        input  req,
        output floor,
        output dir_up,
        output moving,
        output door_open,
        output arrive
    );

    modport slave (
        output req,
        input  floor,
        input  dir_up,
        input  moving,
        input  door_open,
        input  arrive
    );

endinterface

// File: rtl/elev_timer.sv
// ---------------------------------------------------------------------------
// elev_timer
// Loadable count-up timer shared by the MOVE and DOOR phases.
//   clk   : clock
//   clr   : asynchronous active-high reset, clears the count
//   load  : restart the count from zero on the next edge
//   limit : terminal count
//   done  : count has reached limit; the count then holds
// ---------------------------------------------------------------------------
module elev_timer #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [TW-1:0] limit,
    output logic          done
);

    logic [TW-1:0] r_cnt;

    assign done = (r_cnt == limit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (!done) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_ctrl
// SCAN (keep-direction) car scheduler. Samples the per-floor request lines,
// moves the car one floor per MOVE_CYCLES, holds the door for DOOR_CYCLES at
// each served floor and pulses arrive for that floor on arrival.
//   clk : clock, rising edge
//   clr : asynchronous active-high reset
//   bus : elevator_if master (req in; floor, dir_up, moving, door_open,
//         arrive out, all registered)
// ---------------------------------------------------------------------------
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS      = DEF_FLOORS,
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    elevator_if.master  bus
);

    localparam int FW = $clog2(FLOORS);
    localparam int TW = timer_width(MOVE_CYCLES, DOOR_CYCLES);

    elev_state_t       r_state;
    logic [FW-1:0]     r_floor;
    logic              r_dir_up;
    logic              r_moving;
    logic              r_door_open;
    logic [FLOORS-1:0] r_arrive;

    elev_state_t       w_state_nxt;
    logic [FW-1:0]     w_floor_nxt;
    logic              w_dir_nxt;
    logic [FLOORS-1:0] w_arrive_nxt;
    logic              w_load;
    logic              w_done;
    logic [TW-1:0]     w_limit;
    logic              w_above;
    logic              w_below;
    logic [FW-1:0]     w_step_floor;
    logic              w_ahead;

    // Floor the car reaches when the current MOVE interval expires.
    assign w_step_floor = r_dir_up ? (r_floor + FW'(1)) : (r_floor - FW'(1));

    // Request scans: above/below the current floor, and still-ahead of the
    // floor being entered so MOVE can decide whether to keep going.
    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        w_ahead = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            if (f > int'(r_floor)) w_above = w_above | bus.req[f];
            if (f < int'(r_floor)) w_below = w_below | bus.req[f];
            if (r_dir_up  && f > int'(w_step_floor)) w_ahead = w_ahead | bus.req[f];
            if (!r_dir_up && f < int'(w_step_floor)) w_ahead = w_ahead | bus.req[f];
        end
    end

    assign w_limit = (r_state == DOOR) ? TW'(DOOR_CYCLES - 1) : TW'(MOVE_CYCLES - 1);

    elev_timer #(
        .TW (TW)
    ) u_timer (
        .clk   (clk),
        .clr   (clr),
        .load  (w_load),
        .limit (w_limit),
        .done  (w_done)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_nxt    = r_dir_up;
        w_arrive_nxt = '0;
        w_load       = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req[r_floor]) begin
                    w_state_nxt           = DOOR;
                    w_arrive_nxt[r_floor] = 1'b1;
                    w_load                = 1'b1;
                end else if (r_dir_up && w_above) begin
                    w_state_nxt = MOVE;
                    w_load      = 1'b1;
                end else if (!r_dir_up && w_below) begin
                    w_state_nxt = MOVE;
                    w_load      = 1'b1;
                end else if (w_above || w_below) begin
                    // Nothing left in the old direction: reverse in the same
                    // cycle so reversal adds no latency.
                    w_dir_nxt   = !r_dir_up;
                    w_state_nxt = MOVE;
                    w_load      = 1'b1;
                end
            end

            MOVE: begin
                if (w_done) begin
                    w_floor_nxt = w_step_floor;
                    if (bus.req[w_step_floor]) begin
                        w_state_nxt                = DOOR;
                        w_arrive_nxt[w_step_floor] = 1'b1;
                        w_load                     = 1'b1;
                    end else if (w_ahead) begin
                        w_load = 1'b1;
                    end else begin
                        // Target vanished mid-trip; let IDLE re-plan.
                        w_state_nxt = IDLE;
                    end
                end
            end

            DOOR: begin
                // req at this floor is ignored while the button clears.
                if (w_done) w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= IDLE;
            r_floor     <= '0;
            r_dir_up    <= 1'b1;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
            r_arrive    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_floor     <= w_floor_nxt;
            r_dir_up    <= w_dir_nxt;
            r_moving    <= (w_state_nxt == MOVE);
            r_door_open <= (w_state_nxt == DOOR);
            r_arrive    <= w_arrive_nxt;
        end
    end

    assign bus.floor     = r_floor;
    assign bus.dir_up    = r_dir_up;
    assign bus.moving    = r_moving;
    assign bus.door_open = r_door_open;
    assign bus.arrive    = r_arrive;

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Car scheduler for the elevator design: samples the per-floor pending-request lines coming from the `button` latch instances, moves the car floor by floor using a SCAN (keep-direction) policy, and holds the door open at each served floor. On arrival it issues a one-cycle `arrive` pulse for that floor; the pulse drives the button's feedback input so the button clears its request and lamp.

## Interface
- `FLOORS`, 4: number of floors; must be at least 2.
- `MOVE_CYCLES`, 8: clock cycles to travel one floor; must be at least 1.
- `DOOR_CYCLES`, 16: clock cycles the door stays open; must be at least 4, which covers the button's two-register clear latency.
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `clr`, in, 1: asynchronous, active-high reset.
- `req`, in, FLOORS: request pending per floor, bit f = floor f; level from the button latches.
- `floor`, out, clog2(FLOORS): current car floor, binary.
- `dir_up`, out, 1: 1 = current or last direction is up.
- `moving`, out, 1: high while in MOVE.
- `door_open`, out, 1: high while in DOOR.
- `arrive`, out, FLOORS: one-hot, one-cycle pulse at the served floor; goes to the button feedback input.

## Operation
- Reset values while `clr`=1: state IDLE, `floor`=0, `dir_up`=1, `moving`=0, `door_open`=0, `arrive`=0, timer=0.
- Reset mid-move or mid-door aborts immediately. No arrive pulse is issued.
- Define `above` = any req bit above `floor`, and `below` = any req bit below `floor`.
- States: IDLE, MOVE, DOOR. All outputs are registered.
- IDLE, evaluated in priority order:
  - `req[floor]`=1: go to DOOR, `arrive[floor]`=1, load timer.
  - `dir_up` and `above`: go to MOVE up.
  - `!dir_up` and `below`: go to MOVE down.
  - Otherwise, `above` or `below`: flip `dir_up`, then go to MOVE in the new direction.
  - Otherwise stay in IDLE.
- MOVE:
  - The timer counts up to MOVE_CYCLES-1.
  - On the expiry edge, `floor` steps by ±1 per `dir_up`.
  - On that same edge, if `req[new floor]`=1: go to DOOR and pulse `arrive[new floor]`.
  - Else, if requests remain ahead in the current direction: reload the timer and stay in MOVE.
  - Else go to IDLE. This path is defensive only.
- DOOR:
  - The timer counts DOOR_CYCLES.
  - `req[floor]` is ignored throughout, because the button is still clearing.
  - On expiry go to IDLE. IDLE then re-evaluates; a fresh press at the same floor reopens the door.
- `floor` never leaves the range 0..FLOORS-1. At the top floor `above` is 0, and at floor 0 `below` is 0, so no wrap is possible.
- Requests at a floor the car is currently leaving during MOVE are served later by normal scan order.
- Timer width is clog2(max(MOVE_CYCLES, DOOR_CYCLES)) + 1.

## Timing
- From IDLE, a request present at edge E changes state at edge E. Outputs reflect the new state after E.
- Travel from floor a to floor b in one direction: arrival edge is E + |b-a|·MOVE_CYCLES. `floor`, `door_open`=1 and the arrive pulse all appear together after that edge.
- `arrive` is high for exactly one cycle per door opening.
- `door_open` is high for DOOR_CYCLES cycles.
- Direction reversal costs no extra cycle.
- Request at the current floor while in IDLE: DOOR is entered at the next edge (1-cycle latency).

## Structure
- Shared package `elevator_pkg`:
  - state enum `elev_state_t` {IDLE, MOVE, DOOR};
  - default FLOORS constant;
  - floor index type.
- Sub-module `elev_timer`: loadable count-up timer with `load`, `limit` and `done` ports, shared by MOVE and DOOR.
- The `above`/`below` reductions are combinational inside `elevator_ctrl`.
- The top level instantiates FLOORS `button` latches plus this block.

## Test plan
- Reset, then `req`=0: outputs stay at their reset values for 50 cycles; `arrive` never pulses.
- FLOORS=4, MOVE_CYCLES=8. Set `req`=0100 at edge 0 and model the button clearing on arrive:
  - `floor` reads 1 at edge 8 and 2 at edge 16;
  - `arrive`=0100 for one cycle, then `door_open` for 16 cycles.
- Car at floor 2 moving up, `req`=1001: serve floor 3 first, then reverse with `dir_up`=0 and serve floor 0. Arrive pulses in order 1000, then 0001.
- Car idle at floor 1, assert `req[1]`: next cycle `door_open`=1 and `arrive`=0010. Keeping `req[1]` high for 2 cycles (button latency) does not cause a reopen.
- Assert `clr` mid-MOVE, three cycles into the second floor: `floor`=0, state IDLE, no arrive pulse. After release with `req` still set, the trip restarts.
- Press floor 0 while the door is open at floor 0: no extension. Press it again after close: the door reopens via IDLE, and arrive pulses again.
